// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue (rev 1.0): sequential instruction fetcher that buffers up to DEPTH
// {pc, inst} pairs for the decoder and discards cache responses made stale by a flush.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   output logic             icache_req_out,
   output logic [31:0]      icache_addr_out,
   input  logic             icache_grant_in,
   input  logic             icache_valid_in,
   input  logic [31:0]      icache_inst_in,
   output logic             dec_valid_out,
   output logic [31:0]      dec_inst_out,
   output logic [31:0]      dec_pc_out,
   input  logic             dec_ready_in,
   input  logic             dec_redirect_in,
   input  logic [31:0]      dec_redirect_pc_in,
   input  logic             rob_clear_in,
   input  logic [31:0]      rob_rst_addr_in,
   output logic [CNT_W-1:0] count_out
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [31:0]      fetch_pc;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [31:0]      inst_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];

   logic             flush;
   logic [31:0]      flush_target;
   logic             push;
   logic             pop;
   logic             slot_free;

   assign flush        = rob_clear_in | dec_redirect_in;
   assign flush_target = rob_clear_in ? rob_rst_addr_in : dec_redirect_pc_in;
   assign push         = (state == WAIT) & icache_valid_in & ~flush;
   assign pop          = (count != '0) & dec_ready_in & ~flush;

   // An outstanding granted request already owns one slot.
   assign slot_free = ({1'b0, count} + {{CNT_W{1'b0}}, (state == WAIT)}) < (CNT_W + 1)'(DEPTH);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!flush && slot_free) state_nxt = REQ;
         REQ: begin
            if (flush)                state_nxt = IDLE;
            else if (icache_grant_in) state_nxt = WAIT;
         end
         WAIT: begin
            if (icache_valid_in) state_nxt = IDLE;
            else if (flush)      state_nxt = DROP;
         end
         DROP: if (icache_valid_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (rdy_in) begin
         state <= state_nxt;
         if (flush) begin
            fetch_pc <= flush_target;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
         end else begin
            if (push) begin
               tail     <= tail + PTR_W'(1);
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) head <= head + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Storage needs no reset: entries are only observable once counted.
   always_ff @(posedge clk_in) begin
      if (rdy_in && push) begin
         inst_mem[tail] <= icache_inst_in;
         pc_mem[tail]   <= fetch_pc;
      end
   end

   assign icache_req_out  = (state == REQ) & ~flush;
   assign icache_addr_out = fetch_pc;
   assign dec_valid_out   = (count != '0) & ~rob_clear_in;
   assign dec_inst_out    = inst_mem[head];
   assign dec_pc_out      = pc_mem[head];
   assign count_out       = count;

endmodule
`default_nettype wire
